// File: rtl/ysyx_25060170_mem_arbiter.sv
// rtl/ysyx_25060170_mem_arbiter.sv - round-robin IFU/LSU arbiter for the single memory port with response timeout
module ysyx_25060170_mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 256
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_W-1:0]   ifu_addr,
  output logic                ifu_rsp_valid,
  output logic [DATA_W-1:0]   ifu_rsp_data,
  output logic                ifu_rsp_err,
  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic                lsu_wen,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wmask,
  output logic                lsu_rsp_valid,
  output logic [DATA_W-1:0]   lsu_rsp_data,
  output logic                lsu_rsp_err,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_wen,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_rsp_valid,
  input  logic [DATA_W-1:0]   mem_rsp_data
);

  localparam int MASK_W = DATA_W / 8;
  localparam int CNT_W  = $clog2(TIMEOUT);
  // The counter reads 0 in the first REQ cycle, so the error pulse lands
  // TIMEOUT cycles after accept when the last wait cycle sees this value.
  localparam int unsigned LAST_CNT = TIMEOUT - 2;

  localparam logic OWN_IFU = 1'b0;
  localparam logic OWN_LSU = 1'b1;

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                owner_q, owner_d;
  logic                last_grant_q, last_grant_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                wen_q, wen_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [MASK_W-1:0]   wmask_q, wmask_d;
  logic                ifu_rsp_valid_q, ifu_rsp_valid_d;
  logic                ifu_rsp_err_q, ifu_rsp_err_d;
  logic [DATA_W-1:0]   ifu_rsp_data_q, ifu_rsp_data_d;
  logic                lsu_rsp_valid_q, lsu_rsp_valid_d;
  logic                lsu_rsp_err_q, lsu_rsp_err_d;
  logic [DATA_W-1:0]   lsu_rsp_data_q, lsu_rsp_data_d;

  logic grant_lsu, grant_ifu, rsp_done, timed_out, final_cnt;

  // Next-state, grant and response logic; registers hold unless overridden.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    owner_d         = owner_q;
    last_grant_d    = last_grant_q;
    addr_d          = addr_q;
    wen_d           = wen_q;
    wdata_d         = wdata_q;
    wmask_d         = wmask_q;
    ifu_rsp_valid_d = 1'b0;
    ifu_rsp_err_d   = ifu_rsp_err_q;
    ifu_rsp_data_d  = ifu_rsp_data_q;
    lsu_rsp_valid_d = 1'b0;
    lsu_rsp_err_d   = lsu_rsp_err_q;
    lsu_rsp_data_d  = lsu_rsp_data_q;
    ifu_req_ready   = 1'b0;
    lsu_req_ready   = 1'b0;
    rsp_done        = 1'b0;
    timed_out       = 1'b0;

    // On a tie the master that did not win last time gets the port.
    grant_lsu = lsu_req_valid && (!ifu_req_valid || (last_grant_q == OWN_IFU));
    grant_ifu = ifu_req_valid && !grant_lsu;
    final_cnt = (cnt_q == CNT_W'(LAST_CNT));

    case (state_q)
      IDLE: begin
        ifu_req_ready = grant_ifu;
        lsu_req_ready = grant_lsu;
        if (grant_lsu) begin
          addr_d       = lsu_addr;
          wen_d        = lsu_wen;
          wdata_d      = lsu_wdata;
          wmask_d      = lsu_wmask;
          owner_d      = OWN_LSU;
          last_grant_d = OWN_LSU;
          cnt_d        = '0;
          state_d      = REQ;
        end else if (grant_ifu) begin
          addr_d       = ifu_addr;
          wen_d        = 1'b0;
          wdata_d      = '0;
          wmask_d      = '0;
          owner_d      = OWN_IFU;
          last_grant_d = OWN_IFU;
          cnt_d        = '0;
          state_d      = REQ;
        end
      end
      REQ: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (mem_req_ready && mem_rsp_valid) begin
          rsp_done = 1'b1;
        end else if (final_cnt) begin
          timed_out = 1'b1;
        end else if (mem_req_ready) begin
          state_d = RESP;
        end
      end
      RESP: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (mem_rsp_valid) begin
          rsp_done = 1'b1;
        end else if (final_cnt) begin
          timed_out = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (rsp_done || timed_out) begin
      state_d = IDLE;
      if (owner_q == OWN_LSU) begin
        lsu_rsp_valid_d = 1'b1;
        lsu_rsp_err_d   = timed_out;
        lsu_rsp_data_d  = (rsp_done && !wen_q) ? mem_rsp_data : '0;
      end else begin
        ifu_rsp_valid_d = 1'b1;
        ifu_rsp_err_d   = timed_out;
        ifu_rsp_data_d  = rsp_done ? mem_rsp_data : '0;
      end
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      owner_q         <= OWN_IFU;
      last_grant_q    <= OWN_IFU;
      addr_q          <= '0;
      wen_q           <= 1'b0;
      wdata_q         <= '0;
      wmask_q         <= '0;
      ifu_rsp_valid_q <= 1'b0;
      ifu_rsp_err_q   <= 1'b0;
      ifu_rsp_data_q  <= '0;
      lsu_rsp_valid_q <= 1'b0;
      lsu_rsp_err_q   <= 1'b0;
      lsu_rsp_data_q  <= '0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      owner_q         <= owner_d;
      last_grant_q    <= last_grant_d;
      addr_q          <= addr_d;
      wen_q           <= wen_d;
      wdata_q         <= wdata_d;
      wmask_q         <= wmask_d;
      ifu_rsp_valid_q <= ifu_rsp_valid_d;
      ifu_rsp_err_q   <= ifu_rsp_err_d;
      ifu_rsp_data_q  <= ifu_rsp_data_d;
      lsu_rsp_valid_q <= lsu_rsp_valid_d;
      lsu_rsp_err_q   <= lsu_rsp_err_d;
      lsu_rsp_data_q  <= lsu_rsp_data_d;
    end
  end

  assign mem_req_valid = (state_q == REQ);
  assign mem_addr      = addr_q;
  assign mem_wen       = wen_q;
  assign mem_wdata     = wdata_q;
  assign mem_wmask     = wmask_q;
  assign ifu_rsp_valid = ifu_rsp_valid_q;
  assign ifu_rsp_err   = ifu_rsp_err_q;
  assign ifu_rsp_data  = ifu_rsp_data_q;
  assign lsu_rsp_valid = lsu_rsp_valid_q;
  assign lsu_rsp_err   = lsu_rsp_err_q;
  assign lsu_rsp_data  = lsu_rsp_data_q;

endmodule

// File: tb/tb_ysyx_25060170_mem_arbiter.sv
// tb/tb_ysyx_25060170_mem_arbiter.sv - directed and randomized check of the memory arbiter against a transaction model
module tb_ysyx_25060170_mem_arbiter;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req_valid, ifu_req_ready;
  logic [31:0] ifu_addr;
  logic        ifu_rsp_valid, ifu_rsp_err;
  logic [31:0] ifu_rsp_data;
  logic        lsu_req_valid, lsu_req_ready;
  logic [31:0] lsu_addr;
  logic        lsu_wen;
  logic [31:0] lsu_wdata;
  logic [3:0]  lsu_wmask;
  logic        lsu_rsp_valid, lsu_rsp_err;
  logic [31:0] lsu_rsp_data;
  logic        mem_req_valid, mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;

  ysyx_25060170_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_data(ifu_rsp_data), .ifu_rsp_err(ifu_rsp_err),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_data(lsu_rsp_data), .lsu_rsp_err(lsu_rsp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  // Transaction-level model: one outstanding transfer, its age in cycles
  // since accept, and whether memory has taken the request yet.
  bit          m_busy, m_sent, m_owner, m_last;
  int          m_age;
  logic [31:0] m_addr, m_wdata;
  logic        m_wen;
  logic [3:0]  m_wmask;
  bit          e_ifu_v, e_ifu_err, e_lsu_v, e_lsu_err;
  logic [31:0] e_ifu_data, e_lsu_data;
  bit          dead;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit winner();
    if (ifu_req_valid && lsu_req_valid) return !m_last;
    return lsu_req_valid;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_sent = 0; m_owner = 0; m_last = 0; m_age = 0;
    m_addr = '0; m_wen = 1'b0; m_wdata = '0; m_wmask = '0;
    e_ifu_v = 0; e_lsu_v = 0; e_ifu_err = 0; e_lsu_err = 0;
    e_ifu_data = '0; e_lsu_data = '0;
  endtask

  task automatic model_cmp();
    bit any, win;
    any = ifu_req_valid || lsu_req_valid;
    win = winner();
    chk("ifu_req_ready", 64'(ifu_req_ready), 64'(!m_busy && any && !win));
    chk("lsu_req_ready", 64'(lsu_req_ready), 64'(!m_busy && any && win));
    chk("mem_req_valid", 64'(mem_req_valid), 64'(m_busy && !m_sent));
    chk("mem_addr", 64'(mem_addr), 64'(m_addr));
    chk("mem_wen", 64'(mem_wen), 64'(m_wen));
    chk("mem_wdata", 64'(mem_wdata), 64'(m_wdata));
    chk("mem_wmask", 64'(mem_wmask), 64'(m_wmask));
    chk("ifu_rsp_valid", 64'(ifu_rsp_valid), 64'(e_ifu_v));
    chk("lsu_rsp_valid", 64'(lsu_rsp_valid), 64'(e_lsu_v));
    if (e_ifu_v) begin
      chk("ifu_rsp_data", 64'(ifu_rsp_data), 64'(e_ifu_data));
      chk("ifu_rsp_err", 64'(ifu_rsp_err), 64'(e_ifu_err));
    end
    if (e_lsu_v) begin
      chk("lsu_rsp_data", 64'(lsu_rsp_data), 64'(e_lsu_data));
      chk("lsu_rsp_err", 64'(lsu_rsp_err), 64'(e_lsu_err));
    end
  endtask

  // Advance the model across the coming rising edge using the applied inputs.
  task automatic model_step();
    bit done, win;
    logic [31:0] d;
    if (rst) begin
      model_reset();
      return;
    end
    e_ifu_v = 0;
    e_lsu_v = 0;
    if (m_busy) begin
      done = m_sent ? mem_rsp_valid : (mem_req_ready && mem_rsp_valid);
      if (done || m_age == TO - 1) begin
        d = (done && !(m_owner && m_wen)) ? mem_rsp_data : 32'h0;
        if (m_owner) begin
          e_lsu_v = 1; e_lsu_err = !done; e_lsu_data = d;
        end else begin
          e_ifu_v = 1; e_ifu_err = !done; e_ifu_data = d;
        end
        m_busy = 0;
      end else begin
        if (!m_sent && mem_req_ready) m_sent = 1;
        m_age++;
      end
    end else if (ifu_req_valid || lsu_req_valid) begin
      win = winner();
      m_busy = 1; m_sent = 0; m_age = 1; m_owner = win; m_last = win;
      if (win) begin
        m_addr = lsu_addr; m_wen = lsu_wen; m_wdata = lsu_wdata; m_wmask = lsu_wmask;
      end else begin
        m_addr = ifu_addr; m_wen = 1'b0; m_wdata = '0; m_wmask = '0;
      end
    end
  endtask

  task automatic tick();
    #1;
    model_cmp();
    model_step();
    @(negedge clk);
  endtask

  task automatic clear_in();
    ifu_req_valid = 0; ifu_addr = '0;
    lsu_req_valid = 0; lsu_addr = '0; lsu_wen = 0; lsu_wdata = '0; lsu_wmask = '0;
    mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_data = '0;
  endtask

  task automatic do_reset();
    rst = 1;
    tick();
    rst = 0;
  endtask

  task automatic serve(input logic [31:0] data);
    mem_req_ready = 1;
    tick();
    mem_req_ready = 0;
    mem_rsp_valid = 1;
    mem_rsp_data  = data;
    tick();
    mem_rsp_valid = 0;
  endtask

  initial begin
    clear_in();
    dead = 0;
    rst = 1;
    @(negedge clk);
    @(negedge clk);
    model_reset();
    chk("rst_mem_req_valid", 64'(mem_req_valid), 64'h0);
    chk("rst_ifu_rsp_valid", 64'(ifu_rsp_valid), 64'h0);
    chk("rst_lsu_rsp_valid", 64'(lsu_rsp_valid), 64'h0);
    chk("rst_mem_addr", 64'(mem_addr), 64'h0);
    chk("rst_mem_wen", 64'(mem_wen), 64'h0);
    chk("rst_mem_wmask", 64'(mem_wmask), 64'h0);
    rst = 0;

    // Single IFU fetch with an immediately ready memory.
    ifu_req_valid = 1; ifu_addr = 32'h8000_0000; mem_req_ready = 1;
    #1 chk("t1_ifu_ready", 64'(ifu_req_ready), 64'h1);
    tick();
    ifu_req_valid = 0;
    chk("t1_mem_req_valid", 64'(mem_req_valid), 64'h1);
    chk("t1_mem_addr", 64'(mem_addr), 64'h8000_0000);
    chk("t1_mem_wen", 64'(mem_wen), 64'h0);
    tick();
    mem_req_ready = 0; mem_rsp_valid = 1; mem_rsp_data = 32'h0000_0413;
    tick();
    mem_rsp_valid = 0;
    chk("t1_ifu_rsp_valid", 64'(ifu_rsp_valid), 64'h1);
    chk("t1_ifu_rsp_data", 64'(ifu_rsp_data), 64'h413);
    chk("t1_lsu_rsp_valid", 64'(lsu_rsp_valid), 64'h0);
    tick();
    chk("t1_pulse_end", 64'(ifu_rsp_valid), 64'h0);
    clear_in();

    // Tie alternation starting with LSU after reset.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      ifu_req_valid = 1; ifu_addr = 32'h8000_0000 + 32'(i * 4);
      lsu_req_valid = 1; lsu_addr = 32'h8000_1000; lsu_wen = 0;
      #1;
      chk("t2_lsu_ready", 64'(lsu_req_ready), 64'(i % 2 == 0));
      chk("t2_ifu_ready", 64'(ifu_req_ready), 64'(i % 2 == 1));
      tick();
      ifu_req_valid = 0; lsu_req_valid = 0;
      serve(32'(i + 100));
      chk("t2_owner", 64'(lsu_rsp_valid), 64'(i % 2 == 0));
    end
    clear_in();

    // LSU store with memory ready held off for three cycles.
    lsu_req_valid = 1; lsu_addr = 32'h8000_0010; lsu_wen = 1;
    lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'hF;
    tick();
    lsu_req_valid = 0; lsu_addr = '0; lsu_wdata = '0; lsu_wmask = '0; lsu_wen = 0;
    for (int k = 0; k < 4; k++) begin
      mem_req_ready = (k == 3);
      chk("t3_req_valid", 64'(mem_req_valid), 64'h1);
      chk("t3_addr", 64'(mem_addr), 64'h8000_0010);
      chk("t3_wdata", 64'(mem_wdata), 64'hDEAD_BEEF);
      chk("t3_wmask", 64'(mem_wmask), 64'hF);
      chk("t3_wen", 64'(mem_wen), 64'h1);
      tick();
    end
    mem_req_ready = 0; mem_rsp_valid = 1; mem_rsp_data = 32'hCAFE_F00D;
    tick();
    mem_rsp_valid = 0;
    chk("t3_lsu_rsp_valid", 64'(lsu_rsp_valid), 64'h1);
    chk("t3_lsu_rsp_data", 64'(lsu_rsp_data), 64'h0);
    chk("t3_lsu_rsp_err", 64'(lsu_rsp_err), 64'h0);
    chk("t3_ifu_rsp_valid", 64'(ifu_rsp_valid), 64'h0);
    clear_in();

    // Dead memory: error pulse TIMEOUT cycles after accept, then recovery.
    ifu_req_valid = 1; ifu_addr = 32'h8000_0100;
    tick();
    ifu_req_valid = 0;
    for (int k = 1; k < TO; k++) begin
      chk("t4_no_early", 64'(ifu_rsp_valid), 64'h0);
      tick();
    end
    chk("t4_rsp_valid", 64'(ifu_rsp_valid), 64'h1);
    chk("t4_rsp_err", 64'(ifu_rsp_err), 64'h1);
    chk("t4_rsp_data", 64'(ifu_rsp_data), 64'h0);
    chk("t4_req_dropped", 64'(mem_req_valid), 64'h0);
    ifu_req_valid = 1; ifu_addr = 32'h8000_0200;
    #1 chk("t4_next_ready", 64'(ifu_req_ready), 64'h1);
    tick();
    ifu_req_valid = 0;
    chk("t4_next_addr", 64'(mem_addr), 64'h8000_0200);
    serve(32'h0000_0013);
    chk("t4_next_err", 64'(ifu_rsp_err), 64'h0);
    chk("t4_next_data", 64'(ifu_rsp_data), 64'h13);
    clear_in();

    // Reset while waiting in RESP; the late response must be ignored.
    lsu_req_valid = 1; lsu_addr = 32'h8000_2000; lsu_wen = 0;
    tick();
    lsu_req_valid = 0;
    mem_req_ready = 1;
    tick();
    mem_req_ready = 0;
    rst = 1;
    tick();
    rst = 0;
    mem_rsp_valid = 1; mem_rsp_data = 32'h55AA_55AA;
    chk("t5_mem_req_valid", 64'(mem_req_valid), 64'h0);
    chk("t5_mem_addr", 64'(mem_addr), 64'h0);
    tick();
    mem_rsp_valid = 0;
    chk("t5_lsu_rsp_valid", 64'(lsu_rsp_valid), 64'h0);
    chk("t5_ifu_rsp_valid", 64'(ifu_rsp_valid), 64'h0);
    ifu_req_valid = 1; ifu_addr = 32'h8000_0300;
    tick();
    ifu_req_valid = 0;
    serve(32'h0010_0073);
    chk("t5_after_data", 64'(ifu_rsp_data), 64'h0010_0073);
    clear_in();

    // Ready and response in the same cycle.
    ifu_req_valid = 1; ifu_addr = 32'h8000_0400;
    tick();
    ifu_req_valid = 0;
    mem_req_ready = 1; mem_rsp_valid = 1; mem_rsp_data = 32'h1234_5678;
    tick();
    clear_in();
    chk("t6_rsp_valid", 64'(ifu_rsp_valid), 64'h1);
    chk("t6_rsp_data", 64'(ifu_rsp_data), 64'h1234_5678);
    chk("t6_req_valid", 64'(mem_req_valid), 64'h0);
    tick();
    chk("t6_no_dup", 64'(ifu_rsp_valid), 64'h0);
    chk("t6_lsu_quiet", 64'(lsu_rsp_valid), 64'h0);

    // Randomized traffic with a protocol-abiding memory.
    for (int c = 0; c < 4000; c++) begin
      rst           = ($urandom_range(0, 199) == 0);
      ifu_req_valid = 1'($urandom);
      lsu_req_valid = 1'($urandom);
      ifu_addr      = $urandom;
      lsu_addr      = $urandom;
      lsu_wen       = 1'($urandom);
      lsu_wdata     = $urandom;
      lsu_wmask     = 4'($urandom);
      if ($urandom_range(0, 31) == 0) dead = !dead;
      mem_req_ready = !dead && ($urandom_range(0, 2) != 0);
      mem_rsp_data  = $urandom;
      if (m_busy && m_sent)
        mem_rsp_valid = !dead && ($urandom_range(0, 2) == 0);
      else if (m_busy)
        mem_rsp_valid = mem_req_ready && ($urandom_range(0, 3) == 0);
      else
        mem_rsp_valid = ($urandom_range(0, 7) == 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
